// File: rtl/io_bridge_pkg.sv
// Shared definitions for the CPU I/O bridge: FSM state encoding and error codes.
package io_bridge_pkg;

    localparam int unsigned STATE_WIDTH    = 2;
    localparam int unsigned ERR_CODE_WIDTH = 2;

    // Bridge FSM states.
    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Error codes reported in the low bits of the error status word.
    typedef enum logic [ERR_CODE_WIDTH-1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_DECODE   = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_code_t;

endpackage

// File: rtl/io_timeout_counter.sv
// Cycle counter used to bound how long the bridge waits for a peripheral ack.
//  clk       in   clock
//  reset     in   synchronous, active-high reset
//  clear     in   zero the count (takes priority over enable)
//  enable    in   count one cycle
//  count     out  registered cycle count
//  expired_c out  combinational: enabled and count has reached p_timeout-1
module io_timeout_counter #(
    parameter int unsigned p_timeout = 15,
    parameter int unsigned p_width   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [p_width-1:0] count,
    output logic               expired_c
);

    // Count register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + p_width'(1);
        end
    end

    // Last allowed cycle is flagged so the FSM can abort on the same edge.
    assign expired_c = enable && (count == p_width'(p_timeout - 1));

endmodule

// File: rtl/io_bridge.sv
// Multi-channel bridge between the CPU I/O port and req/ack peripherals.
// Stalls the CPU while a peripheral access is outstanding, aborts on timeout,
// and keeps a sticky error status word.
//  i_w_clk, i_w_reset        clock, synchronous active-high reset
//  i_w_io_oe / i_w_io_we     CPU read / write request levels
//  i_w_io_port               [sel-1:0] channel, upper bits peripheral register
//  i_w_io_in / o_w_io_out    CPU write data / registered read data
//  o_w_io_wait               combinational stall to the control unit
//  o_w_per_*                 shared peripheral request bus (one-hot req)
//  i_w_per_ack / _rdata      per-channel ack and flattened read data
//  i_w_err_clear             clears o_w_err_status = {0, err_chan, err_code}
//  o_w_state_disp_out        debug builds only: {0, state, counter}
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned p_data_width = 16,
    parameter int unsigned p_port_width = 8,
    parameter int unsigned p_channels   = 4,
    parameter int unsigned p_timeout    = 15
) (
    input  logic                                         i_w_clk,
    input  logic                                         i_w_reset,
    input  logic                                         i_w_io_oe,
    input  logic                                         i_w_io_we,
    input  logic [p_port_width-1:0]                      i_w_io_port,
    input  logic [p_data_width-1:0]                      i_w_io_in,
    output logic [p_data_width-1:0]                      o_w_io_out,
    output logic                                         o_w_io_wait,
    output logic [p_channels-1:0]                        o_w_per_req,
    output logic                                         o_w_per_we,
    output logic [p_port_width-$clog2(p_channels)-1:0]   o_w_per_addr,
    output logic [p_data_width-1:0]                      o_w_per_wdata,
    input  logic [p_channels-1:0]                        i_w_per_ack,
    input  logic [p_channels*p_data_width-1:0]           i_w_per_rdata,
    input  logic                                         i_w_err_clear,
`ifdef DEBUG
    output logic [p_data_width-1:0]                      o_w_state_disp_out,
`endif
    output logic [p_data_width-1:0]                      o_w_err_status
);

    localparam int unsigned l_p_sel_width  = $clog2(p_channels);
    localparam int unsigned l_p_cnt_width  = $clog2(p_timeout + 1);
    localparam int unsigned l_p_addr_width = p_port_width - l_p_sel_width;

    state_t                      state, state_nxt;
    logic [l_p_sel_width-1:0]    chan_q, chan_nxt;
    logic [p_channels-1:0]       req_q, req_nxt;
    logic                        we_q, we_nxt;
    logic [l_p_addr_width-1:0]   addr_q, addr_nxt;
    logic [p_data_width-1:0]     wdata_q, wdata_nxt;
    logic [p_data_width-1:0]     io_out_q, io_out_nxt;
    logic [p_data_width-1:0]     err_q, err_nxt;

    logic [l_p_sel_width-1:0]    port_chan_c;
    logic [l_p_addr_width-1:0]   port_addr_c;
    logic                        chan_valid_c;
    logic                        ack_sel_c;
    logic [p_data_width-1:0]     rdata_sel_c;
    logic                        cnt_clear_c;
    logic                        cnt_enable_c;
    logic                        expired_c;
    logic [l_p_cnt_width-1:0]    cnt;

    // Error status word: {zeros, channel, code}.
    function automatic logic [p_data_width-1:0] err_word(
        input logic [l_p_sel_width-1:0] chan,
        input err_code_t                code
    );
        logic [p_data_width-1:0] w;
        w = '0;
        w[l_p_sel_width+1:0] = {chan, code};
        return w;
    endfunction

    // Port decode and selected-channel views.
    assign port_chan_c  = i_w_io_port[l_p_sel_width-1:0];
    assign port_addr_c  = i_w_io_port[p_port_width-1:l_p_sel_width];
    // Only meaningful if p_channels is ever not a power of two.
    assign chan_valid_c = (l_p_sel_width+1)'(port_chan_c) < (l_p_sel_width+1)'(p_channels);
    assign ack_sel_c    = i_w_per_ack[chan_q];
    assign rdata_sel_c  = i_w_per_rdata[32'(chan_q) * p_data_width +: p_data_width];

    // Counter runs only while a request is outstanding.
    assign cnt_clear_c  = (state != ST_REQ);
    assign cnt_enable_c = (state == ST_REQ);

    io_timeout_counter #(
        .p_timeout (p_timeout),
        .p_width   (l_p_cnt_width)
    ) u_timeout (
        .clk       (i_w_clk),
        .reset     (i_w_reset),
        .clear     (cnt_clear_c),
        .enable    (cnt_enable_c),
        .count     (cnt),
        .expired_c (expired_c)
    );

    // State register.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_w_io_oe && i_w_io_we) begin
                    state_nxt = ST_DONE;
                end else if (i_w_io_oe || i_w_io_we) begin
                    state_nxt = chan_valid_c ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                // Ack takes priority over the timeout on the same cycle.
                if (ack_sel_c || expired_c) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A held request must drop before the next access is accepted.
                if (!(i_w_io_oe || i_w_io_we)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and transaction latches.
    always_comb begin
        chan_nxt   = chan_q;
        req_nxt    = req_q;
        we_nxt     = we_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        io_out_nxt = io_out_q;
        // A new error raised this cycle overrides a simultaneous clear.
        err_nxt    = i_w_err_clear ? '0 : err_q;
        case (state)
            ST_IDLE: begin
                if (i_w_io_oe && i_w_io_we) begin
                    err_nxt = err_word(port_chan_c, ERR_CONFLICT);
                end else if (i_w_io_oe || i_w_io_we) begin
                    chan_nxt  = port_chan_c;
                    we_nxt    = i_w_io_we;
                    addr_nxt  = port_addr_c;
                    wdata_nxt = i_w_io_in;
                    if (chan_valid_c) begin
                        req_nxt              = '0;
                        req_nxt[port_chan_c] = 1'b1;
                    end else begin
                        io_out_nxt = '1;
                        err_nxt    = err_word(port_chan_c, ERR_DECODE);
                    end
                end
            end
            ST_REQ: begin
                if (ack_sel_c) begin
                    req_nxt = '0;
                    if (!we_q) begin
                        io_out_nxt = rdata_sel_c;
                    end
                end else if (expired_c) begin
                    req_nxt    = '0;
                    io_out_nxt = '1;
                    err_nxt    = err_word(chan_q, ERR_TIMEOUT);
                end
            end
            default: req_nxt = '0;
        endcase
    end

    // Transaction latches and output registers.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            chan_q   <= '0;
            req_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            io_out_q <= '0;
            err_q    <= '0;
        end else begin
            chan_q   <= chan_nxt;
            req_q    <= req_nxt;
            we_q     <= we_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            io_out_q <= io_out_nxt;
            err_q    <= err_nxt;
        end
    end

    assign o_w_io_wait    = (i_w_io_oe || i_w_io_we) && (state != ST_DONE);
    assign o_w_per_req    = req_q;
    assign o_w_per_we     = we_q;
    assign o_w_per_addr   = addr_q;
    assign o_w_per_wdata  = wdata_q;
    assign o_w_io_out     = io_out_q;
    assign o_w_err_status = err_q;

`ifdef DEBUG
    assign o_w_state_disp_out = p_data_width'({state, cnt});
`else
    // Counter value is only observed in debug builds.
    logic unused_cnt_c;
    assign unused_cnt_c = ^cnt;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Directed and randomized checks of io_bridge against a transaction-level model.
module tb_io_bridge;

    localparam int unsigned W   = 16;
    localparam int unsigned PW  = 8;
    localparam int unsigned NCH = 4;
    localparam int unsigned T   = 15;

    logic              clk = 1'b0;
    logic              i_w_reset;
    logic              i_w_io_oe;
    logic              i_w_io_we;
    logic [PW-1:0]     i_w_io_port;
    logic [W-1:0]      i_w_io_in;
    logic [W-1:0]      o_w_io_out;
    logic              o_w_io_wait;
    logic [NCH-1:0]    o_w_per_req;
    logic              o_w_per_we;
    logic [PW-3:0]     o_w_per_addr;
    logic [W-1:0]      o_w_per_wdata;
    logic [NCH-1:0]    i_w_per_ack;
    logic [NCH*W-1:0]  i_w_per_rdata;
    logic              i_w_err_clear;
    logic [W-1:0]      o_w_err_status;

    int total = 0;
    int bad   = 0;

    // Model of the architecturally visible registers.
    logic [W-1:0] exp_io_out;
    logic [W-1:0] exp_err;

    io_bridge #(
        .p_data_width (W),
        .p_port_width (PW),
        .p_channels   (NCH),
        .p_timeout    (T)
    ) dut (
        .i_w_clk        (clk),
        .i_w_reset      (i_w_reset),
        .i_w_io_oe      (i_w_io_oe),
        .i_w_io_we      (i_w_io_we),
        .i_w_io_port    (i_w_io_port),
        .i_w_io_in      (i_w_io_in),
        .o_w_io_out     (o_w_io_out),
        .o_w_io_wait    (o_w_io_wait),
        .o_w_per_req    (o_w_per_req),
        .o_w_per_we     (o_w_per_we),
        .o_w_per_addr   (o_w_per_addr),
        .o_w_per_wdata  (o_w_per_wdata),
        .i_w_per_ack    (i_w_per_ack),
        .i_w_per_rdata  (i_w_per_rdata),
        .i_w_err_clear  (i_w_err_clear),
        .o_w_err_status (o_w_err_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] err_val(input int ch, input logic [1:0] code);
        return {12'h000, 2'(ch), code};
    endfunction

    // One CPU access starting at a negedge. ack_at is the index of the request
    // cycle in which the peripheral acks (-1 or >= T means it never acks in time).
    // Ends at a negedge with the bridge back in idle.
    task automatic run_txn(input bit oe, input bit we, input logic [7:0] port,
                           input logic [15:0] wd, input int ack_at, input logic [15:0] rd,
                           input bit stray, input int hold, input bit clr_with);
        int ch;
        int req_cycles;
        int req_cnt;
        int low_at;
        int quiet_bad;
        bit conflict;
        bit ack_win;
        bit req_ok;
        ch       = int'(port[1:0]);
        conflict = oe && we;
        ack_win  = !conflict && ack_at >= 0 && ack_at < int'(T);
        if (conflict)     req_cycles = 0;
        else if (ack_win) req_cycles = ack_at + 1;
        else              req_cycles = int'(T);

        for (int k = 0; k < int'(NCH); k++) begin
            i_w_per_rdata[k*W +: W] = (k == ch) ? rd : 16'($urandom);
        end
        i_w_io_oe     = oe;
        i_w_io_we     = we;
        i_w_io_port   = port;
        i_w_io_in     = wd;
        i_w_err_clear = clr_with;
        #1;
        chk("wait_at_start", 32'(o_w_io_wait), 32'd1);

        req_cnt = 0;
        low_at  = -1;
        req_ok  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            i_w_err_clear = 1'b0;
            if (o_w_per_req !== '0) begin
                req_cnt++;
                if (o_w_per_req !== 4'(1 << ch)) req_ok = 1'b0;
            end
            if (o_w_io_wait === 1'b0) begin
                low_at = c;
                break;
            end
            i_w_per_ack = '0;
            if (c == ack_at + 1) i_w_per_ack[ch] = 1'b1;
            if (stray) i_w_per_ack[(ch + 2) % int'(NCH)] = 1'b1;
        end
        i_w_per_ack = '0;

        chk("req_cycles", 32'(req_cnt), 32'(req_cycles));
        chk("req_onehot", 32'(req_ok), 32'd1);
        chk("wait_low_cycle", 32'(low_at), 32'(req_cycles + 1));

        if (clr_with) exp_err = '0;
        if (conflict) begin
            exp_err = err_val(ch, 2'b11);
        end else if (ack_win) begin
            if (!we) exp_io_out = rd;
        end else begin
            exp_io_out = 16'hFFFF;
            exp_err    = err_val(ch, 2'b01);
        end

        chk("io_out_done", 32'(o_w_io_out), 32'(exp_io_out));
        chk("err_status_done", 32'(o_w_err_status), 32'(exp_err));
        if (!conflict) begin
            chk("per_we", 32'(o_w_per_we), 32'(we));
            chk("per_addr", 32'(o_w_per_addr), 32'(port[7:2]));
            chk("per_wdata", 32'(o_w_per_wdata), 32'(wd));
        end

        // CPU keeps the request asserted: no re-issue, no stall.
        quiet_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (o_w_io_wait !== 1'b0 || o_w_per_req !== '0) quiet_bad++;
        end
        if (hold > 0) chk("held_quiet", 32'(quiet_bad), 32'd0);

        i_w_io_oe = 1'b0;
        i_w_io_we = 1'b0;
        @(negedge clk);
        chk("idle_req", 32'(o_w_per_req), 32'd0);
        chk("idle_io_out", 32'(o_w_io_out), 32'(exp_io_out));
    endtask

    task automatic pulse_clear();
        i_w_err_clear = 1'b1;
        @(negedge clk);
        i_w_err_clear = 1'b0;
        exp_err = '0;
        chk("err_clear", 32'(o_w_err_status), 32'd0);
    endtask

    initial begin
        i_w_reset     = 1'b1;
        i_w_io_oe     = 1'b0;
        i_w_io_we     = 1'b0;
        i_w_io_port   = '0;
        i_w_io_in     = '0;
        i_w_per_ack   = '0;
        i_w_per_rdata = '0;
        i_w_err_clear = 1'b0;
        exp_io_out    = '0;
        exp_err       = '0;
        repeat (2) @(negedge clk);
        i_w_reset = 1'b0;
        @(negedge clk);

        chk("rst_req", 32'(o_w_per_req), 32'd0);
        chk("rst_io_out", 32'(o_w_io_out), 32'd0);
        chk("rst_err", 32'(o_w_err_status), 32'd0);
        chk("rst_we", 32'(o_w_per_we), 32'd0);
        chk("rst_addr", 32'(o_w_per_addr), 32'd0);
        chk("rst_wdata", 32'(o_w_per_wdata), 32'd0);
        chk("rst_wait", 32'(o_w_io_wait), 32'd0);

        // Read ch2, ack in the third request cycle, stray ack on ch0.
        run_txn(1'b1, 1'b0, 8'h0E, 16'h0000, 2, 16'hBEEF, 1'b1, 0, 1'b0);
        // Write ch1, ack in the first request cycle.
        run_txn(1'b0, 1'b1, 8'h05, 16'h1234, 0, 16'h5555, 1'b0, 0, 1'b0);
        // Read ch3 with no ack: timeout.
        run_txn(1'b1, 1'b0, 8'h07, 16'h0000, -1, 16'h7777, 1'b0, 0, 1'b0);
        chk("timeout_status", 32'(o_w_err_status), 32'h000D);
        // Read/write conflict, then clear.
        run_txn(1'b1, 1'b1, 8'h02, 16'h0000, 0, 16'h0000, 1'b0, 0, 1'b0);
        chk("conflict_code", 32'(o_w_err_status[1:0]), 32'd3);
        pulse_clear();
        // Conflict raised in the same cycle as a clear: error wins.
        run_txn(1'b1, 1'b1, 8'h01, 16'h0000, 0, 16'h0000, 1'b0, 0, 1'b1);
        pulse_clear();
        // Ack on the last allowed cycle beats the timeout; one later times out.
        run_txn(1'b1, 1'b0, 8'h10, 16'h0000, int'(T) - 1, 16'hA5A5, 1'b0, 0, 1'b0);
        chk("ack_at_limit_err", 32'(o_w_err_status), 32'd0);
        run_txn(1'b1, 1'b0, 8'h10, 16'h0000, int'(T), 16'h5A5A, 1'b0, 0, 1'b0);
        // Held read: one request pulse, then re-arm after one idle cycle.
        run_txn(1'b1, 1'b0, 8'h09, 16'h0000, 1, 16'hC0DE, 1'b1, 4, 1'b0);
        run_txn(1'b1, 1'b0, 8'h09, 16'h0000, 0, 16'hCAFE, 1'b0, 2, 1'b0);

        // Reset in the middle of a request.
        i_w_io_oe   = 1'b1;
        i_w_io_port = 8'h0E;
        repeat (3) @(negedge clk);
        chk("pre_reset_req", 32'(o_w_per_req), 32'h4);
        i_w_reset = 1'b1;
        @(negedge clk);
        exp_io_out = '0;
        exp_err    = '0;
        chk("midrst_req", 32'(o_w_per_req), 32'd0);
        chk("midrst_io_out", 32'(o_w_io_out), 32'd0);
        chk("midrst_err", 32'(o_w_err_status), 32'd0);
        chk("midrst_wait", 32'(o_w_io_wait), 32'd1);
        i_w_reset = 1'b0;
        i_w_io_oe = 1'b0;
        @(negedge clk);
        chk("post_reset_wait", 32'(o_w_io_wait), 32'd0);

        // Randomized accesses.
        for (int n = 0; n < 40; n++) begin
            int r;
            bit oe;
            bit we;
            r  = int'($urandom_range(0, 9));
            oe = (r == 0) || (r < 5);
            we = (r == 0) || (r >= 5);
            run_txn(oe, we, 8'($urandom), 16'($urandom), int'($urandom_range(0, 18)),
                    16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) pulse_clear();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
